// File: rtl/buzzer_pkg.sv
// Shared types and constants for the buzzer beeper.
// Register map, state encoding and duration helper.
package buzzer_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] REG_HALF  = 2'd0;
    localparam logic [1:0] REG_ON    = 2'd1;
    localparam logic [1:0] REG_OFF   = 2'd2;
    localparam logic [1:0] REG_COUNT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

    // A zero duration still lasts one tick.
    function automatic logic [DATA_W-1:0] eff_dur(
        input logic [DATA_W-1:0] v
    );
        return (v == '0) ? DATA_W'(1) : v;
    endfunction

endpackage

// File: rtl/buzzer_beeper_if.sv
// Avalon-MM slave bus bundle for the buzzer beeper.
// Reads are zero-wait-state and combinational.
interface buzzer_beeper_if;
    import buzzer_pkg::*;

    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/buzzer_tick_gen.sv
// Duration prescaler: one-cycle tick every TICKDIV clocks.
// restart zeroes the count so a new phase starts on a clean boundary.
module buzzer_tick_gen #(
    parameter int TICKDIV = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKDIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/buzzer_beeper.sv
// Beep-pattern generator: tone counter, ON/OFF phase FSM and
// register file behind an Avalon-MM slave port.
module buzzer_beeper
    import buzzer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int TICKDIV = CLK_HZ / TICK_HZ
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    buzzer_beeper_if.slave  bus,
    output logic            buzz_out,
    output logic            busy
);

    logic [DATA_W-1:0] half_q;
    logic [DATA_W-1:0] on_q;
    logic [DATA_W-1:0] off_q;
    logic [14:0]       rem_q;
    logic [14:0]       rem_d;
    state_t            state_q;
    state_t            state_d;
    logic              enter_on;
    logic              enter_off;
    logic              tick;
    logic              phase_end;
    logic [DATA_W-1:0] dur_q;
    logic [DATA_W-1:0] phase_q;
    logic [DATA_W-1:0] tone_q;
    logic              wr;
    logic              count_wr;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign count_wr = wr && (bus.address == REG_COUNT);

    buzzer_tick_gen #(
        .TICKDIV (TICKDIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (enter_on | enter_off),
        .tick    (tick)
    );

    assign phase_end = tick && (phase_q == dur_q - 1'b1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            half_q <= '0;
            on_q   <= '0;
            off_q  <= '0;
        end else if (wr) begin
            unique case (bus.address)
                REG_HALF:  half_q <= bus.writedata;
                REG_ON:    on_q   <= bus.writedata;
                REG_OFF:   off_q  <= bus.writedata;
                REG_COUNT: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            busy    <= (state_d != IDLE);
        end
    end

    // enable low wins over everything, then COUNT writes, then timing.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        enter_on  = 1'b0;
        enter_off = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (count_wr) begin
            rem_d = bus.writedata[14:0];
            if (bus.writedata[14:0] != '0) begin
                state_d  = ON;
                enter_on = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                ON: begin
                    if (phase_end) begin
                        if (rem_q > 15'd1) begin
                            state_d   = OFF;
                            enter_off = 1'b1;
                            rem_d     = rem_q - 1'b1;
                        end else begin
                            state_d = IDLE;
                            rem_d   = '0;
                        end
                    end
                end
                OFF: begin
                    if (phase_end) begin
                        state_d  = ON;
                        enter_on = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dur_q   <= '0;
            phase_q <= '0;
        end else if (enter_on) begin
            dur_q   <= eff_dur(on_q);
            phase_q <= '0;
        end else if (enter_off) begin
            dur_q   <= eff_dur(off_q);
            phase_q <= '0;
        end else if (tick && state_q != IDLE) begin
            phase_q <= phase_q + 1'b1;
        end
    end

    // Comparing against the live HALF_PERIOD lets a rewrite land at the next toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tone_q   <= '0;
            buzz_out <= 1'b0;
        end else if (state_d != ON) begin
            tone_q   <= '0;
            buzz_out <= 1'b0;
        end else if (enter_on) begin
            tone_q   <= '0;
            buzz_out <= (half_q != '0);
        end else if (half_q == '0) begin
            tone_q   <= '0;
            buzz_out <= 1'b0;
        end else if ({1'b0, tone_q} + 17'd1 >= {1'b0, half_q}) begin
            tone_q   <= '0;
            buzz_out <= ~buzz_out;
        end else begin
            tone_q <= tone_q + 1'b1;
        end
    end

    always_comb begin
        bus.readdata = '0;
        unique case (bus.address)
            REG_HALF:  bus.readdata = half_q;
            REG_ON:    bus.readdata = on_q;
            REG_OFF:   bus.readdata = off_q;
            REG_COUNT: bus.readdata = {busy, rem_q};
        endcase
    end

endmodule

// File: tb/tb_buzzer_beeper.sv
// Self-checking bench for buzzer_beeper (TICKDIV = 10).
module tb_buzzer_beeper;
    import buzzer_pkg::*;

    localparam int TD = 10;

    logic clk = 1'b0;
    logic reset_n;
    logic enable;
    logic buzz_out;
    logic busy;

    int checks = 0;
    int errors = 0;

    buzzer_beeper_if bus ();

    buzzer_beeper #(
        .CLK_HZ  (1000),
        .TICK_HZ (100)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .bus      (bus.master),
        .buzz_out (buzz_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Writes at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [1:0] a, input int d);
        bus.address    = a;
        bus.writedata  = 16'(d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = REG_COUNT;
    endtask

    // Expected outputs t cycles after the starting COUNT write.
    task automatic model(
        input  int t, input int h, input int on, input int off, input int cnt,
        output logic eb, output logic ebusy, output logic [15:0] erd
    );
        int on_c, off_c, p, total, k, pos, rem;
        on_c  = ((on == 0) ? 1 : on) * TD;
        off_c = ((off == 0) ? 1 : off) * TD;
        p     = on_c + off_c;
        total = cnt * on_c + (cnt - 1) * off_c;
        eb = 1'b0; ebusy = 1'b0; erd = 16'h0000;
        if (t < total) begin
            k   = t / p;
            pos = t % p;
            ebusy = 1'b1;
            if (pos < on_c) begin
                rem = cnt - k;
                eb  = (h != 0) && (((pos / h) % 2) == 0);
            end else begin
                rem = cnt - k - 1;
            end
            erd = 16'h8000 | 16'(rem);
        end
    endtask

    task automatic test_reset();
        logic [1:0] a;
        checks++;
        if (buzz_out !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: buzz=%b busy=%b want 0 0", buzz_out, busy);
        end
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            bus.address = a;
            #1;
            checks++;
            if (bus.readdata !== 16'h0000) begin
                errors++;
                $display("FAIL reset_read%0d: got %h want 0000", i, bus.readdata);
            end
        end
        bus.address = REG_COUNT;
        @(negedge clk);
    endtask

    task automatic run_seq(
        input string nm, input int h, input int on, input int off, input int cnt
    );
        logic eb, ebusy;
        logic [15:0] erd;
        int on_c, off_c, total;
        on_c  = ((on == 0) ? 1 : on) * TD;
        off_c = ((off == 0) ? 1 : off) * TD;
        total = cnt * on_c + (cnt - 1) * off_c;
        wr(REG_HALF, h);
        wr(REG_ON, on);
        wr(REG_OFF, off);
        wr(REG_COUNT, cnt);
        for (int t = 0; t < total + 4; t++) begin
            model(t, h, on, off, cnt, eb, ebusy, erd);
            checks++;
            if (buzz_out !== eb || busy !== ebusy || bus.readdata !== erd) begin
                errors++;
                $display("FAIL %s t=%0d: buzz=%b busy=%b rd=%h want %b %b %h",
                         nm, t, buzz_out, busy, bus.readdata, eb, ebusy, erd);
            end
            @(negedge clk);
        end
        bus.address = REG_HALF;
        #1;
        checks++;
        if (bus.readdata !== 16'(h)) begin
            errors++;
            $display("FAIL %s half_rd: got %h want %h", nm, bus.readdata, 16'(h));
        end
        bus.address = REG_COUNT;
        @(negedge clk);
    endtask

    task automatic test_random();
        int h, on, off, cnt;
        for (int i = 0; i < 6; i++) begin
            h   = $urandom_range(0, 4);
            on  = $urandom_range(0, 3);
            off = $urandom_range(0, 2);
            cnt = $urandom_range(1, 3);
            run_seq("random", h, on, off, cnt);
        end
    endtask

    task automatic test_abort();
        wr(REG_HALF, 1);
        wr(REG_ON, 3);
        wr(REG_COUNT, 2);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        checks++;
        if (buzz_out !== 1'b0 || busy !== 1'b0 || bus.readdata !== 16'h0000) begin
            errors++;
            $display("FAIL abort: buzz=%b busy=%b rd=%h want 0 0 0000",
                     buzz_out, busy, bus.readdata);
        end
        wr(REG_COUNT, 5);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (buzz_out !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_nostart%0d: buzz=%b busy=%b want 0 0",
                         i, buzz_out, busy);
            end
            @(negedge clk);
        end
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_restart_stop();
        logic eb, ebusy;
        logic [15:0] erd;
        wr(REG_HALF, 1);
        wr(REG_ON, 1);
        wr(REG_OFF, 2);
        wr(REG_COUNT, 2);
        repeat (15) @(negedge clk);
        checks++;
        if (buzz_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL in_off: buzz=%b busy=%b want 0 1", buzz_out, busy);
        end
        wr(REG_COUNT, 4);
        for (int t = 0; t < 5; t++) begin
            model(t, 1, 1, 2, 4, eb, ebusy, erd);
            checks++;
            if (buzz_out !== eb || busy !== ebusy || bus.readdata !== erd) begin
                errors++;
                $display("FAIL restart t=%0d: buzz=%b busy=%b rd=%h want %b %b %h",
                         t, buzz_out, busy, bus.readdata, eb, ebusy, erd);
            end
            @(negedge clk);
        end
        wr(REG_COUNT, 0);
        checks++;
        if (buzz_out !== 1'b0 || busy !== 1'b0 || bus.readdata !== 16'h0000) begin
            errors++;
            $display("FAIL stop: buzz=%b busy=%b rd=%h want 0 0 0000",
                     buzz_out, busy, bus.readdata);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        wr(REG_HALF, 1);
        wr(REG_ON, 3);
        wr(REG_COUNT, 1);
        repeat (4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (buzz_out !== 1'b0 || busy !== 1'b0 || bus.readdata !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: buzz=%b busy=%b rd=%h want 0 0 0000",
                     buzz_out, busy, bus.readdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        bus.address = REG_ON;
        #1;
        checks++;
        if (bus.readdata !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset_reg: got %h want 0000", bus.readdata);
        end
        bus.address = REG_COUNT;
        @(negedge clk);
    endtask

    initial begin
        reset_n        = 1'b0;
        enable         = 1'b0;
        bus.address    = REG_COUNT;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        enable = 1'b1;
        run_seq("single", 2, 3, 0, 1);
        run_seq("repeat", 1, 2, 1, 3);
        test_abort();
        test_restart_stop();
        run_seq("silent", 0, 2, 0, 1);
        run_seq("on_zero", 1, 0, 0, 2);
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
